sample_scheduler: RTL

- Controller that sequences writes into the stopwatch Stash, sitting between the debounced btnD, the Ctl FSM outputs, and the Stash sample_in_valid input.
- Merges manual sample requests with optional periodic auto-samples taken every PERIOD_SEC seconds of running stopwatch time.
- Guarantees one single-cycle write pulse per accepted request, enforces a minimum gap between pulses, and tracks Stash occupancy and dropped requests.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/sample_interval_timer.sv | 51 +++++
 rtl/sample_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sample path: scheduler FSM
// encoding, default clock rate and Stash fill-counter width.
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } sched_state_t;

    localparam int c_CLK_FREQ_DEFAULT = 100_000_000;
    localparam int c_STASH_DEPTH      = 5;
    localparam int c_FILL_W           = $clog2(c_STASH_DEPTH + 1);

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_interval_timer.sv
// Periodic auto-sample timebase: 1-second prescaler plus seconds counter that
// pauses while disabled and pulses o_tick combinationally on the final second.
`default_nettype none

module sample_interval_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ   = c_CLK_FREQ_DEFAULT,
    parameter int PERIOD_SEC = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int c_PW = cnt_width(CLK_FREQ);
    localparam int c_SW = cnt_width(PERIOD_SEC);
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(CLK_FREQ - 1);
    localparam logic [c_SW-1:0] c_SEC_MAX = c_SW'(PERIOD_SEC - 1);

    logic [c_PW-1:0] r_pre;
    logic [c_SW-1:0] r_sec;
    logic            w_pre_wrap;
    logic            w_sec_wrap;

    assign w_pre_wrap = i_enable & (r_pre == c_PRE_MAX);
    assign w_sec_wrap = (r_sec == c_SEC_MAX);
    assign o_tick     = ~i_clear & w_pre_wrap & w_sec_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (i_clear) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (i_enable) begin
            if (w_pre_wrap) begin
                r_pre <= '0;
                r_sec <= w_sec_wrap ? '0 : r_sec + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sample_scheduler.sv
// Stash write sequencer: merges manual and periodic requests into single write
// pulses with holdoff, tracks fill level and drops. Option: SAMPLE_SCHED_WRAP_EN.
`default_nettype none

module sample_scheduler
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ       = c_CLK_FREQ_DEFAULT,
    parameter int PERIOD_SEC     = 10,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int DEPTH          = c_STASH_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                count_enabled,
    input  logic                init_regs,
    input  logic                manual_sample,
    input  logic                auto_en,
    output logic                sample_in_valid,
    output logic [c_FILL_W-1:0] fill_count,
    output logic                stash_full,
    output logic [7:0]          drop_cnt,
    output logic                busy
);

    localparam int c_HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [c_HW-1:0]     c_HOLD_MAX = c_HW'(HOLDOFF_CYCLES - 1);
    localparam logic [c_FILL_W-1:0] c_DEPTH_F  = c_FILL_W'(DEPTH);

    sched_state_t          r_state;
    logic                  r_manual_prev;
    logic                  r_pend_man;
    logic                  r_pend_auto;
    logic [c_HW-1:0]       r_hold;
    logic                  r_valid;
    logic                  r_busy;
    logic [c_FILL_W-1:0]   r_fill;
    logic [7:0]            r_drop;

    logic w_man_req;
    logic w_auto_req;
    logic w_req;
    logic w_hold_done;
    logic w_pending_any;
    logic w_full;
    logic w_reject;
    logic w_decide;
    logic w_fire;
    logic w_drop;

    sample_interval_timer #(
        .CLK_FREQ   (CLK_FREQ),
        .PERIOD_SEC (PERIOD_SEC)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (count_enabled & auto_en),
        .i_clear  (init_regs),
        .o_tick   (w_auto_req)
    );

    assign w_man_req     = manual_sample & ~r_manual_prev;
    assign w_req         = w_man_req | w_auto_req;
    assign w_hold_done   = (r_hold == c_HOLD_MAX);
    // Zeroing the stopwatch discards anything queued behind the current pulse.
    assign w_pending_any = ~init_regs & (r_pend_man | r_pend_auto | w_req);
    assign w_full        = (r_fill == c_DEPTH_F);

`ifdef SAMPLE_SCHED_WRAP_EN
    assign w_reject = 1'b0;
`else
    assign w_reject = w_full;
`endif

    assign w_decide = ((r_state == ST_IDLE) && w_req) ||
                      ((r_state == ST_HOLDOFF) && w_hold_done && w_pending_any);
    assign w_fire   = w_decide & ~w_reject;
    assign w_drop   = w_decide & w_reject;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_manual_prev <= 1'b0;
            r_pend_man    <= 1'b0;
            r_pend_auto   <= 1'b0;
            r_hold        <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_fill        <= '0;
            r_drop        <= '0;
        end else begin
            r_manual_prev <= manual_sample;
            r_valid       <= 1'b0;

            if (w_fire && !w_full)
                r_fill <= r_fill + 1'b1;
            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_state <= ST_FIRE;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    r_state <= ST_HOLDOFF;
                    r_hold  <= '0;
                    if (init_regs) begin
                        r_pend_man  <= 1'b0;
                        r_pend_auto <= 1'b0;
                    end else begin
                        r_pend_man  <= r_pend_man  | w_man_req;
                        r_pend_auto <= r_pend_auto | w_auto_req;
                    end
                end
                ST_HOLDOFF: begin
                    if (w_hold_done) begin
                        r_pend_man  <= 1'b0;
                        r_pend_auto <= 1'b0;
                        if (w_fire) begin
                            r_state <= ST_FIRE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                        if (init_regs) begin
                            r_pend_man  <= 1'b0;
                            r_pend_auto <= 1'b0;
                        end else begin
                            r_pend_man  <= r_pend_man  | w_man_req;
                            r_pend_auto <= r_pend_auto | w_auto_req;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_in_valid = r_valid;
    assign fill_count      = r_fill;
    assign stash_full      = w_full;
    assign drop_cnt        = r_drop;
    assign busy            = r_busy;

endmodule

`default_nettype wire
